// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: opcode/funct codes, mult/div FSM encodings and the
// load-use hazard helper used by the hazard controller.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  localparam int MD_LATENCY_DEF = 32;

  // $zero is never a real producer, so a load into r0 cannot create a hazard.
  function automatic logic load_use_hit(input logic       ex_memread,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       id_uses_rt);
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline is the master,
// the hazard controller the slave.
interface hazard_ctrl_if;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRt;
  logic       ID_MDStart;
  logic       ID_ReadsHiLo;
  logic [4:0] EX_Rt;
  logic       EX_MemRead;
  logic       EX_BranchTaken;
  logic       stall;
  logic       stall2;
  logic       PC_Enable;
  logic       IF_ID_Flush;
  logic       ID_EX_Bubble;
  logic       MD_Busy;
  logic       MD_Done;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_MDStart, ID_ReadsHiLo,
           EX_Rt, EX_MemRead, EX_BranchTaken,
    input  stall, stall2, PC_Enable, IF_ID_Flush, ID_EX_Bubble, MD_Busy, MD_Done
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_MDStart, ID_ReadsHiLo,
           EX_Rt, EX_MemRead, EX_BranchTaken,
    output stall, stall2, PC_Enable, IF_ID_Flush, ID_EX_Bubble, MD_Busy, MD_Done
  );
endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Mult/div busy timer: IDLE/BUSY machine with an 8-bit down-counter that holds
// BUSY for MD_LATENCY cycles, then emits a one-cycle registered done pulse.
module md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [7:0] CNT_INIT = 8'(MD_LATENCY - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == MD_IDLE) begin
      if (start) begin
        state_d = MD_BUSY;
        cnt_d   = CNT_INIT;
      end
    end else begin
      // Leave on zero rather than decrementing, so the counter never wraps.
      if (cnt_q == 8'd0) begin
        state_d = MD_IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, mult/div busy stall, and
// branch-redirect flush/bubble generation.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  logic load_use;
  logic stall;
  logic stall2;
  logic md_busy;
  logic md_done;
  logic md_start;

  assign load_use = load_use_hit(hz.EX_MemRead, hz.EX_Rt, hz.ID_Rs, hz.ID_Rt, hz.ID_UsesRt);

  // A redirect squashes the ID instruction anyway, so holding it would be wasted.
  assign stall  = load_use & ~hz.EX_BranchTaken;
  assign stall2 = md_busy & (hz.ID_MDStart | hz.ID_ReadsHiLo) & ~hz.EX_BranchTaken;

  assign md_start = hz.ID_MDStart & ~stall & ~stall2 & ~hz.EX_BranchTaken;

  md_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clock (clock),
    .reset (reset),
    .start (md_start),
    .busy  (md_busy),
    .done  (md_done)
  );

  assign hz.stall        = stall;
  assign hz.stall2       = stall2;
  assign hz.PC_Enable    = ~(stall | stall2);
  assign hz.IF_ID_Flush  = hz.EX_BranchTaken;
  assign hz.ID_EX_Bubble = stall | stall2 | hz.EX_BranchTaken;
  assign hz.MD_Busy      = md_busy;
  assign hz.MD_Done      = md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MD_LATENCY=4; expected outputs
// are queued by the stimulus and checked by an independent monitor.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if hz();

  hazard_ctrl #(
    .MD_LATENCY (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bits: {stall, stall2, PC_Enable, IF_ID_Flush, ID_EX_Bubble, MD_Busy, MD_Done}
  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string name, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                      input logic md_start, input logic hilo,
                      input logic [4:0] ex_rt, input logic memread, input logic br,
                      input logic [6:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    hz.ID_Rs             = rs;
    hz.ID_Rt             = rt;
    hz.ID_UsesRt         = uses_rt;
    hz.ID_MDStart        = md_start;
    hz.ID_ReadsHiLo      = hilo;
    hz.EX_Rt             = ex_rt;
    hz.EX_MemRead        = memread;
    hz.EX_BranchTaken    = br;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: the outputs are valid every cycle, so consume one expectation per cycle.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {hz.stall, hz.stall2, hz.PC_Enable, hz.IF_ID_Flush,
               hz.ID_EX_Bubble, hz.MD_Busy, hz.MD_Done};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (stall,stall2,pc_en,flush,bubble,busy,done)",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    hz.ID_Rs             = 5'd0;
    hz.ID_Rt             = 5'd0;
    hz.ID_UsesRt         = 1'b0;
    hz.ID_MDStart        = 1'b0;
    hz.ID_ReadsHiLo      = 1'b0;
    hz.EX_Rt             = 5'd0;
    hz.EX_MemRead        = 1'b0;
    hz.EX_BranchTaken    = 1'b0;

    //    name               rst rs     rt     urt md  hl exrt   mr  br  expected
    step("reset_idle",       1, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010000);
    step("reset_comb_lu",    1, 5'd5, 5'd0, 0,  0,  0, 5'd5, 1,  0,  7'b1000100);
    step("load_use_rs",      0, 5'd5, 5'd0, 0,  0,  0, 5'd5, 1,  0,  7'b1000100);
    step("load_use_rt",      0, 5'd3, 5'd7, 1,  0,  0, 5'd7, 1,  0,  7'b1000100);
    step("rt_not_used",      0, 5'd3, 5'd7, 0,  0,  0, 5'd7, 1,  0,  7'b0010000);
    step("r0_no_hazard",     0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 1,  0,  7'b0010000);
    step("redirect_lu",      0, 5'd5, 5'd0, 0,  0,  0, 5'd5, 1,  1,  7'b0011100);
    step("md_blocked_lu",    0, 5'd5, 5'd0, 0,  1,  0, 5'd5, 1,  0,  7'b1000100);
    step("md_blocked_br",    0, 5'd0, 5'd0, 0,  1,  0, 5'd0, 0,  1,  7'b0011100);
    step("md_start",         0, 5'd0, 5'd0, 0,  1,  0, 5'd0, 0,  0,  7'b0010000);
    step("busy1_alu",        0, 5'd2, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010010);
    step("busy2_mflo",       0, 5'd0, 5'd0, 0,  0,  1, 5'd0, 0,  0,  7'b0100110);
    step("busy3_mflo_br",    0, 5'd0, 5'd0, 0,  0,  1, 5'd0, 0,  1,  7'b0011110);
    step("busy4_both",       0, 5'd5, 5'd0, 0,  0,  1, 5'd5, 1,  0,  7'b1100110);
    step("done_restart",     0, 5'd0, 5'd0, 0,  1,  1, 5'd0, 0,  0,  7'b0010001);
    step("b2b_busy1",        0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010010);
    step("b2b_busy2",        0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010010);
    step("b2b_busy3_md",     0, 5'd0, 5'd0, 0,  1,  0, 5'd0, 0,  0,  7'b0100110);
    step("b2b_busy4",        0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010010);
    step("b2b_done",         0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010001);
    step("b2b_idle",         0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010000);
    step("rst_md_start",     0, 5'd0, 5'd0, 0,  1,  0, 5'd0, 0,  0,  7'b0010000);
    step("rst_busy1",        0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010010);
    step("rst_busy2_assert", 1, 5'd0, 5'd0, 0,  0,  1, 5'd0, 0,  0,  7'b0100110);
    step("rst_after_hilo",   0, 5'd0, 5'd0, 0,  0,  1, 5'd0, 0,  0,  7'b0010000);
    step("rst_no_done1",     0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010000);
    step("rst_no_done2",     0, 5'd0, 5'd0, 0,  0,  0, 5'd0, 0,  0,  7'b0010000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
